instr_fetch: RTL and testbench

Instruction fetch stage sitting directly upstream of `cpuController`: walks a word-addressed program counter, issues read requests to instruction memory over a req/ack handshake, buffers returned 16-bit words in a small prefetch FIFO, and presents them as `opcode` with a valid/ready handshake. Supports redirect (branch/jump) with FIFO flush and discard of an in-flight memory response.

---
 rtl/instr_fetch.sv | 175 +++++++++++++++++
 tb/tb_instr_fetch.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC walker, req/ack memory read port and a prefetch FIFO feeding opcode.
// Optional IFETCH_STATS_EN adds saturating fetched/dropped word counters.
module instr_fetch #(
    parameter int                ADDR_W   = 16,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [15:0]       mem_rdata,
    output logic [15:0]       opcode,
    output logic [ADDR_W-1:0] opcode_pc,
    output logic              opcode_valid,
    input  logic              opcode_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [1:0]        fsm_state
`ifdef IFETCH_STATS_EN
    ,
    output logic [15:0]       stat_fetched,
    output logic [15:0]       stat_dropped
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [15:0]       word_mem [DEPTH];
    logic [15:0]       head_word_q, head_word_d;
    logic [ADDR_W-1:0] head_pc_q, head_pc_d;
    logic              push, pop, room;

    // Handshakes: a memory transfer completes on any cycle with mem_req && mem_ack;
    // an opcode transfer completes on any cycle with opcode_valid && opcode_ready.
    // Redirect wins over both: the returned word and the popped head are discarded.
    assign push = (state_q == REQ) && mem_ack && !redirect;
    assign pop  = opcode_valid && opcode_ready && !redirect;

    assign count_d  = redirect ? '0 : count_q + CNT_W'(push) - CNT_W'(pop);
    assign rd_ptr_d = redirect ? '0 : rd_ptr_q + PTR_W'(pop);
    assign wr_ptr_d = redirect ? '0 : wr_ptr_q + PTR_W'(push);
    // A new request is only issued when its FIFO slot is already guaranteed.
    assign room     = count_d < CNT_W'(DEPTH);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        if (state_q == REQ && mem_ack) begin
            fetch_pc_d = fetch_pc_q + ADDR_W'(1);
        end
        if (redirect) begin
            fetch_pc_d = redirect_pc;
        end
        case (state_q)
            IDLE: begin
                if (room) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (redirect && !mem_ack) begin
                    state_d = DROP;
                end else if (mem_ack) begin
                    state_d = room ? REQ : IDLE;
                end
            end
            DROP: begin
                if (mem_ack) begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Head of FIFO after this cycle; a word pushed into an empty (or emptying) FIFO bypasses storage.
    always_comb begin
        head_word_d = head_word_q;
        head_pc_d   = head_pc_q;
        if (count_d != '0) begin
            if (push && (wr_ptr_q == rd_ptr_d)) begin
                head_word_d = mem_rdata;
                head_pc_d   = addr_q;
            end else begin
                head_word_d = word_mem[rd_ptr_d];
                head_pc_d   = pc_mem[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            fetch_pc_q  <= RESET_PC;
            addr_q      <= RESET_PC;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            head_word_q <= '0;
            head_pc_q   <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            // In DROP the old address stays on the bus until its ack arrives.
            if (state_d != DROP) begin
                addr_q <= fetch_pc_d;
            end
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            head_word_q <= head_word_d;
            head_pc_q   <= head_pc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]   <= addr_q;
            word_mem[wr_ptr_q] <= mem_rdata;
        end
    end

    assign mem_req      = (state_q != IDLE);
    assign mem_addr     = addr_q;
    assign opcode       = head_word_q;
    assign opcode_pc    = head_pc_q;
    assign opcode_valid = (count_q != '0);
    assign fsm_state    = state_q;

`ifdef IFETCH_STATS_EN
    logic        discard;
    logic [16:0] drop_sum;

    assign discard = mem_ack && ((state_q == DROP) || (state_q == REQ && redirect));

    always_comb begin
        drop_sum = {1'b0, stat_dropped};
        if (redirect) begin
            drop_sum = drop_sum + 17'(count_q);
        end
        if (discard) begin
            drop_sum = drop_sum + 17'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_fetched <= '0;
            stat_dropped <= '0;
        end else begin
            if (pop && (stat_fetched != 16'hFFFF)) begin
                stat_fetched <= stat_fetched + 16'd1;
            end
            stat_dropped <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: streaming, back-pressure, redirect/DROP, PC wrap and async reset.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] opcode;
    logic [15:0] opcode_pc;
    logic        opcode_valid;
    logic        opcode_ready = 1'b0;
    logic        redirect     = 1'b0;
    logic [15:0] redirect_pc  = '0;
    logic [1:0]  fsm_state;
`ifdef IFETCH_STATS_EN
    logic [15:0] stat_fetched;
    logic [15:0] stat_dropped;
`endif

    int n_vec = 0;
    int n_bad = 0;
    int lat   = 0;
    int wait_cnt;
    logic [15:0] exp_q[$];
    logic [15:0] exp_w;

    always #5 clk = ~clk;

    instr_fetch #(.ADDR_W(16), .DEPTH(4), .RESET_PC(16'h0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .opcode       (opcode),
        .opcode_pc    (opcode_pc),
        .opcode_valid (opcode_valid),
        .opcode_ready (opcode_ready),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .fsm_state    (fsm_state)
`ifdef IFETCH_STATS_EN
        ,
        .stat_fetched (stat_fetched),
        .stat_dropped (stat_dropped)
`endif
    );

    // Memory model: word = address, ack after `lat` waiting cycles (0 = same cycle as req).
    assign mem_ack   = mem_req && (wait_cnt >= lat);
    assign mem_rdata = mem_addr;

    always @(posedge clk or negedge rst) begin
        if (!rst) wait_cnt <= 0;
        else if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        // Reset values and zero-wait streaming, word = address.
        opcode_ready = 1'b1;
        lat = 0;
        @(negedge clk);
        check("rst_req", mem_req, 0);
        check("rst_addr", mem_addr, 16'h0000);
        check("rst_opcode", opcode, 0);
        check("rst_opc_pc", opcode_pc, 0);
        check("rst_valid", opcode_valid, 0);
        check("rst_state", fsm_state, 0);
`ifdef IFETCH_STATS_EN
        check("rst_stat_f", stat_fetched, 0);
        check("rst_stat_d", stat_dropped, 0);
`endif
        rst = 1'b1;
        @(negedge clk);
        check("first_req", mem_req, 1);
        check("first_addr", mem_addr, 16'h0000);
        check("first_valid", opcode_valid, 0);
        for (int i = 0; i < 6; i++) exp_q.push_back(16'(i));
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            exp_w = exp_q.pop_front();
            check("stream_valid", opcode_valid, 1);
            check("stream_opcode", opcode, exp_w);
            check("stream_pc", opcode_pc, exp_w);
        end

        // Back-pressure: FIFO fills to 4, request stops, then drains and resumes at PC 4.
        opcode_ready = 1'b0;
        apply_reset();
        repeat (6) @(negedge clk);
        check("full_req", mem_req, 0);
        check("full_valid", opcode_valid, 1);
        check("full_opcode", opcode, 16'h0000);
        check("full_addr", mem_addr, 16'h0004);
        opcode_ready = 1'b1;
        for (int i = 1; i <= 4; i++) exp_q.push_back(16'(i));
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 1) begin
                check("resume_req", mem_req, 1);
                check("resume_addr", mem_addr, 16'h0004);
            end
            exp_w = exp_q.pop_front();
            check("drain_opcode", opcode, exp_w);
            check("drain_pc", opcode_pc, exp_w);
        end

        // Redirect while a 3-cycle-latency request is outstanding -> DROP.
        lat = 3;
        apply_reset();
        repeat (2) @(negedge clk);
        redirect = 1'b1;
        redirect_pc = 16'h0100;
        @(negedge clk);
        redirect = 1'b0;
        check("drop_state", fsm_state, 2);
        check("drop_req", mem_req, 1);
        check("drop_addr_held", mem_addr, 16'h0000);
        @(negedge clk);
        check("drop_state2", fsm_state, 2);
        check("drop_valid", opcode_valid, 0);
        @(negedge clk);
        check("after_drop_state", fsm_state, 1);
        check("after_drop_addr", mem_addr, 16'h0100);
        check("after_drop_valid", opcode_valid, 0);
        repeat (3) begin
            @(negedge clk);
            check("no_stale_valid", opcode_valid, 0);
        end
        @(negedge clk);
        check("target_valid", opcode_valid, 1);
        check("target_opcode", opcode, 16'h0100);
        check("target_pc", opcode_pc, 16'h0100);

        // Redirect coinciding with mem_ack and opcode_ready.
        lat = 0;
        apply_reset();
        repeat (4) @(negedge clk);
        check("pre_redir_opcode", opcode, 16'h0002);
        redirect = 1'b1;
        redirect_pc = 16'h0200;
        @(negedge clk);
        redirect = 1'b0;
        check("redir_valid", opcode_valid, 0);
        check("redir_req", mem_req, 1);
        check("redir_addr", mem_addr, 16'h0200);
`ifdef IFETCH_STATS_EN
        check("redir_stat_f", stat_fetched, 2);
        check("redir_stat_d", stat_dropped, 2);
`endif
        @(negedge clk);
        check("redir_new_valid", opcode_valid, 1);
        check("redir_new_opcode", opcode, 16'h0200);
        check("redir_new_pc", opcode_pc, 16'h0200);

        // PC wrap through 0xFFFF.
        redirect = 1'b1;
        redirect_pc = 16'hFFFF;
        @(negedge clk);
        redirect = 1'b0;
        check("wrap_addr", mem_addr, 16'hFFFF);
        check("wrap_valid", opcode_valid, 0);
        @(negedge clk);
        check("wrap_opcode_ffff", opcode, 16'hFFFF);
        check("wrap_pc_ffff", opcode_pc, 16'hFFFF);
        check("wrap_next_addr", mem_addr, 16'h0000);
        @(negedge clk);
        check("wrap_opcode_0", opcode, 16'h0000);
        check("wrap_pc_0", opcode_pc, 16'h0000);
        @(negedge clk);
        check("wrap_opcode_1", opcode, 16'h0001);

        // Asynchronous reset while a request is waiting for its ack.
        opcode_ready = 1'b0;
        lat = 3;
        repeat (2) @(negedge clk);
        check("pre_rst_req", mem_req, 1);
        check("pre_rst_opcode", opcode, 16'h0001);
        rst = 1'b0;
        #1;
        check("async_req", mem_req, 0);
        check("async_addr", mem_addr, 16'h0000);
        check("async_opcode", opcode, 0);
        check("async_opc_pc", opcode_pc, 0);
        check("async_valid", opcode_valid, 0);
        check("async_state", fsm_state, 0);
`ifdef IFETCH_STATS_EN
        check("async_stat_f", stat_fetched, 0);
        check("async_stat_d", stat_dropped, 0);
`endif
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("restart_req", mem_req, 1);
        check("restart_addr", mem_addr, 16'h0000);
        repeat (4) @(negedge clk);
        check("restart_valid", opcode_valid, 1);
        check("restart_pc", opcode_pc, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
